// File: rtl/conv_result_streamer.sv
// Output stage for the 2D convolution core: captures a ROWS x COLS block of results,
// requantizes each to OUT_W bits and streams them row-major over valid/ready.

module conv_requant #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 4,
    parameter int RELU  = 0
) (
    input  logic signed [IN_W-1:0]  x,
    output logic signed [OUT_W-1:0] y
);
    localparam logic signed [IN_W-1:0] MAX_V = IN_W'((1 << (OUT_W-1)) - 1);
    localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

    logic signed [IN_W-1:0] v;

    always_comb begin
        v = x >>> SHIFT;
        if (RELU != 0 && v[IN_W-1]) v = '0;
        if (v > MAX_V)      y = MAX_V[OUT_W-1:0];
        else if (v < MIN_V) y = MIN_V[OUT_W-1:0];
        else                y = v[OUT_W-1:0];
    end
endmodule

module conv_result_streamer #(
    parameter int ROWS  = 6,
    parameter int COLS  = 6,
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 4,
    parameter int RELU  = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      blk_valid,
    input  logic [ROWS*COLS*IN_W-1:0] blk_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [OUT_W-1:0]          m_data,
    output logic                      m_last,
    output logic [2:0]                m_row,
    output logic [2:0]                m_col,
    output logic                      busy,
    output logic                      overflow
);
    localparam int N  = ROWS * COLS;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                     state, state_nxt;
    logic [N-1:0][OUT_W-1:0]    q, buf_q;
    logic [PW-1:0]              pos;
    logic [2:0]                 row, col;
    logic                       fire, at_last, final_xfer, capture, drop;

    // Requantize at capture time so the buffer only holds OUT_W-bit samples.
    generate
        for (genvar e = 0; e < N; e++) begin : g_rq
            conv_requant #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .RELU(RELU)) u_rq (
                .x(blk_data[e*IN_W +: IN_W]),
                .y(q[e])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        at_last    = (row == 3'(ROWS-1)) && (col == 3'(COLS-1));
        fire       = (state == STREAM) && m_ready;
        final_xfer = fire && at_last;
        // A block arriving on the final transfer is taken back-to-back; otherwise it's dropped.
        capture    = blk_valid && ((state == IDLE) || final_xfer);
        drop       = blk_valid && !capture;
        m_valid    = (state == STREAM);
        busy       = (state == STREAM);
        m_data     = '0;
        m_last     = 1'b0;
        m_row      = '0;
        m_col      = '0;
        case (state)
            IDLE: if (blk_valid) state_nxt = STREAM;
            STREAM: begin
                m_data = buf_q[pos];
                m_last = at_last;
                m_row  = row;
                m_col  = col;
                if (final_xfer && !blk_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q    <= '0;
            pos      <= '0;
            row      <= '0;
            col      <= '0;
            overflow <= 1'b0;
        end else begin
            if (drop) overflow <= 1'b1;
            if (capture) begin
                buf_q <= q;
                pos   <= '0;
                row   <= '0;
                col   <= '0;
            end else if (final_xfer) begin
                pos <= '0;
                row <= '0;
                col <= '0;
            end else if (fire) begin
                pos <= pos + 1'b1;
                if (col == 3'(COLS-1)) begin
                    col <= '0;
                    row <= row + 3'd1;
                end else begin
                    col <= col + 3'd1;
                end
            end
        end
    end
endmodule

// File: doc/conv_result_streamer.md
# conv_result_streamer

Output stage placed directly downstream of the 2D convolution core. Captures one complete 6x6 block of signed 16-bit convolution results when the core pulses its done strobe. Requantizes each result to signed 8 bits (arithmetic shift, optional ReLU, saturation). Streams the results row-major over a valid/ready interface, so the wide parallel result array never has to leave the convolution processor.

## Interface

Parameters:
- ROWS, 6: result rows per block
- COLS, 6: result columns per block
- IN_W, 16: signed input result width
- OUT_W, 8: signed output sample width
- SHIFT, 4: arithmetic right shift applied before saturation (0..IN_W-1)
- RELU, 0: 1 = clamp negative values to 0 after the shift

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high
- blk_valid  input  1  one-cycle strobe from the conv core; blk_data is valid in this cycle
- blk_data  input  ROWS*COLS*IN_W  flattened result array; element (r,c) at bits [(r*COLS+c)*IN_W +: IN_W]
- m_valid  output  1  output sample valid
- m_ready  input  1  downstream ready
- m_data  output  OUT_W  requantized signed sample
- m_last  output  1  high with the final element (ROWS-1,COLS-1) of a block
- m_row  output  3  row index of the current sample
- m_col  output  3  column index of the current sample
- busy  output  1  block held or streaming (state STREAM)
- overflow  output  1  sticky: a block was dropped because the streamer was busy

## Operation

- Two states: IDLE and STREAM.
- IDLE:
  - blk_valid=1 registers all of blk_data into the internal buffer.
  - Clears the index (row 0, col 0) and moves to STREAM.
- STREAM:
  - m_valid=1; m_data/m_row/m_col/m_last reflect buffer[idx].
  - A transfer occurs on a cycle with m_valid & m_ready; the index then advances col-first, wrapping col COLS-1 -> 0 and incrementing row.
  - The transfer with m_last=1 returns the block to IDLE.
- Requantize, per element x:
  - v = x >>> SHIFT (floor).
  - If RELU=1 and v<0, v=0.
  - Saturate v to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Outputs are stable while m_valid=1 and m_ready=0.
- m_data, m_row, m_col and m_last are 0 whenever m_valid=0.
- Boundary rules:
  - blk_valid in STREAM, other than the final-transfer cycle: block dropped, buffer unchanged, overflow set.
  - blk_valid in the same cycle as the final transfer (m_last & m_ready): new block captured, state stays STREAM, index resets to 0, no overflow.
  - reset at any time, including mid-stream: all state cleared, the in-flight block is discarded.
  - overflow clears only on reset.

## Timing

- Reset values: m_valid=0, m_data=0, m_last=0, m_row=0, m_col=0, busy=0, overflow=0.
- Latency: blk_valid at cycle t -> m_valid=1 with element (0,0) at cycle t+1.
- With m_ready held 1: beats occur at cycles t+1..t+36; m_last=1 at t+36; m_valid=0 at t+37 unless a back-to-back block was captured.
- Each m_ready=0 cycle extends the stream by exactly one cycle.
- busy tracks the state: high from t+1 through the final-transfer cycle.
- overflow goes high the cycle after the dropped blk_valid.

## Test plan

- Reset: assert reset for 2 cycles with random inputs -> every output 0; no m_valid afterwards without blk_valid.
- Ramp, ready high: element (r,c) = 16*(r*6+c), SHIFT=4 -> 36 beats at t+1..t+36, m_data = 0..35 in order, m_row/m_col correct, m_last only on beat 36, busy low at t+37.
- Arithmetic corners, SHIFT=4:
  - RELU=0: 0x0123 -> 0x12; -300 -> 0xED (-19); 32767 -> 0x7F; -32768 -> 0x80.
  - RELU=1: -300 -> 0x00.
- Backpressure: m_ready pattern 1,0,1,0,... -> 36 transfers in 71 cycles; m_data, m_row, m_col and m_last held during every stall; no sample lost or duplicated.
- Collision:
  - Second blk_valid at beat 10 -> ignored, overflow=1 next cycle, first block completes unchanged.
  - Third blk_valid on the final-transfer cycle -> captured; its element (0,0) appears the next cycle; overflow stays as before.
- Reset mid-stream: reset at beat 20 -> m_valid=0 and busy=0 the next cycle; a new block afterwards streams from (0,0) correctly.
